// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: in-order FIFO of committed stores drained to data memory
// as word-aligned writes with byte enables, plus a load-overlap check against pending stores.
module store_drain_buffer #(
    parameter int unsigned SDB_DEPTH  = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic [DATA_WIDTH-1:0]          enq_addr,
    input  logic [DATA_WIDTH-1:0]          enq_data,
    input  logic [1:0]                     enq_size,
    output logic                           misalign_err,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [DATA_WIDTH-1:0]          mem_req_addr,
    output logic [DATA_WIDTH-1:0]          mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]        mem_req_be,
    input  logic [DATA_WIDTH-1:0]          ld_chk_addr,
    input  logic [1:0]                     ld_chk_size,
    output logic                           ld_conflict,
    output logic                           empty,
    output logic [$clog2(SDB_DEPTH):0]     count
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned PTR_W = $clog2(SDB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
    } entry_t;

    entry_t             entry_q [SDB_DEPTH];
    entry_t             entry_d [SDB_DEPTH];
    logic [SDB_DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               misalign_q, misalign_d;

    logic               enq_fire, enq_bad, push, pop;
    logic [BE_W-1:0]    ld_mask;

    function automatic logic [BE_W-1:0] gen_be(input logic [OFF_W-1:0] off,
                                               input logic [1:0] size);
        logic [BE_W-1:0] be;
        case (size)
            SZ_BYTE: be = BE_W'(4'b0001) << off;
            SZ_HALF: be = BE_W'(4'b0011) << off;
            SZ_WORD: be = BE_W'(4'b1111) << off;
            default: be = '0;
        endcase
        return be;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] insert_bytes(input logic [DATA_WIDTH-1:0] data,
                                                           input logic [OFF_W-1:0] off,
                                                           input logic [1:0] size);
        logic [DATA_WIDTH-1:0] masked;
        case (size)
            SZ_BYTE: masked = DATA_WIDTH'(data[7:0]);
            SZ_HALF: masked = DATA_WIDTH'(data[15:0]);
            default: masked = DATA_WIDTH'(data[31:0]);
        endcase
        return masked << {off, 3'b000};
    endfunction

    assign enq_ready     = count_q < CNT_W'(SDB_DEPTH);
    assign empty         = count_q == '0;
    assign count         = count_q;
    assign misalign_err  = misalign_q;
    assign mem_req_valid = !empty;
    assign mem_req_addr  = entry_q[head_q].addr;
    assign mem_req_wdata = entry_q[head_q].wdata;
    assign mem_req_be    = entry_q[head_q].be;

    // Misaligned/RSVD stores are consumed but never written into the FIFO.
    always_comb begin
        enq_bad = 1'b0;
        case (enq_size)
            SZ_BYTE: enq_bad = 1'b0;
            SZ_HALF: enq_bad = enq_addr[0];
            SZ_WORD: enq_bad = enq_addr[OFF_W-1:0] != '0;
            default: enq_bad = 1'b1;
        endcase
    end

    assign enq_fire = enq_valid && enq_ready;
    assign push     = enq_fire && !enq_bad;
    assign pop      = mem_req_valid && mem_req_ready;

    always_comb begin
        entry_d    = entry_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        misalign_d = enq_fire && enq_bad;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            entry_d[tail_q].addr  = {enq_addr[DATA_WIDTH-1:OFF_W], OFF_W'(0)};
            entry_d[tail_q].be    = gen_be(enq_addr[OFF_W-1:0], enq_size);
            entry_d[tail_q].wdata = insert_bytes(enq_data, enq_addr[OFF_W-1:0], enq_size);
            valid_d[tail_q]       = 1'b1;
            tail_d                = tail_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
    end

    // Entries in their dequeue cycle are still valid here and so still flag conflicts.
    always_comb begin
        ld_mask     = gen_be(ld_chk_addr[OFF_W-1:0], ld_chk_size);
        ld_conflict = 1'b0;
        for (int i = 0; i < int'(SDB_DEPTH); i++) begin
            if (valid_q[i] &&
                entry_q[i].addr[DATA_WIDTH-1:OFF_W] == ld_chk_addr[DATA_WIDTH-1:OFF_W] &&
                |(entry_q[i].be & ld_mask)) begin
                ld_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < int'(SDB_DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            for (int i = 0; i < int'(SDB_DEPTH); i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: memory writes checked via a scoreboard queue.
module tb_store_drain_buffer;

    localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid, enq_ready;
    logic [31:0] enq_addr, enq_data;
    logic [1:0]  enq_size;
    logic        misalign_err;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic [31:0] ld_chk_addr;
    logic [1:0]  ld_chk_size;
    logic        ld_conflict, empty;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    store_drain_buffer #(.SDB_DEPTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_data(enq_data), .enq_size(enq_size),
        .misalign_err(misalign_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .ld_chk_addr(ld_chk_addr), .ld_chk_size(ld_chk_size),
        .ld_conflict(ld_conflict), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t w;
        w.addr = a; w.wdata = d; w.be = be;
        exp_q.push_back(w);
    endtask

    // Present one store and hold it until accepted (bounded).
    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int n = 0;
        enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_size = sz;
        while (!enq_ready && n < 50) begin
            tick();
            n++;
        end
        if (!enq_ready) check("enq_timeout", 32'd1, 32'd0);
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        mem_req_ready = 1'b1;
        while (!empty && n < 50) begin
            tick();
            n++;
        end
        check("drain_done", 32'(empty), 32'd1);
        mem_req_ready = 1'b0;
    endtask

    // Monitor: every memory handshake is compared against the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && mem_req_valid && mem_req_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", mem_req_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_addr", mem_req_addr, w.addr);
                    check("wr_data", mem_req_wdata, w.wdata);
                    check("wr_be", 32'(mem_req_be), 32'(w.be));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_size = SB;
        mem_req_ready = 1'b0; ld_chk_addr = 32'hFFFF_0000; ld_chk_size = SB;

        tick(); tick();
        reset = 1'b0;
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_conflict", 32'(ld_conflict), 32'd0);

        // SB placement into the top byte lane
        push_exp(32'h1000, 32'hA500_0000, 4'b1000);
        enq(32'h1003, 32'h0000_00A5, SB);
        check("sb_valid", 32'(mem_req_valid), 32'd1);
        check("sb_addr", mem_req_addr, 32'h1000);
        check("sb_be", 32'(mem_req_be), 32'h8);
        check("sb_wdata", mem_req_wdata, 32'hA500_0000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("sb_empty_after", 32'(empty), 32'd1);

        // Fill and backpressure
        for (int i = 0; i < 4; i++) begin
            push_exp(32'h100 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF);
            enq(32'h100 + 32'(i * 4), 32'h1000_0000 + 32'(i), SW);
        end
        check("full_count", 32'(count), 32'd4);
        check("full_enq_ready", 32'(enq_ready), 32'd0);
        push_exp(32'h110, 32'h1000_0004, 4'hF);
        enq_valid = 1'b1; enq_addr = 32'h110; enq_data = 32'h1000_0004; enq_size = SW;
        tick();
        check("stall_count", 32'(count), 32'd4);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("one_drain_count", 32'(count), 32'd3);
        check("one_drain_ready", 32'(enq_ready), 32'd1);
        tick();
        enq_valid = 1'b0;
        check("fifth_accepted", 32'(count), 32'd4);
        drain_all();

        // Simultaneous enqueue and dequeue
        push_exp(32'h200, 32'h1111_1111, 4'hF);
        push_exp(32'h204, 32'h2222_2222, 4'hF);
        push_exp(32'h200, 32'hBEEF_0000, 4'b1100);
        enq(32'h200, 32'h1111_1111, SW);
        enq(32'h204, 32'h2222_2222, SW);
        check("sim_pre_count", 32'(count), 32'd2);
        enq_valid = 1'b1; enq_addr = 32'h202; enq_data = 32'h0000_BEEF; enq_size = SH;
        mem_req_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        mem_req_ready = 1'b0;
        check("sim_count", 32'(count), 32'd2);
        drain_all();

        // Load conflict against a pending byte store
        push_exp(32'h300, 32'h0000_005A, 4'b0001);
        enq(32'h300, 32'h0000_005A, SB);
        ld_chk_addr = 32'h301; ld_chk_size = SB; #1;
        check("ld_lb_301", 32'(ld_conflict), 32'd0);
        ld_chk_addr = 32'h300; ld_chk_size = SH; #1;
        check("ld_lh_300", 32'(ld_conflict), 32'd1);
        ld_chk_addr = 32'h304; ld_chk_size = SW; #1;
        check("ld_lw_304", 32'(ld_conflict), 32'd0);
        drain_all();
        ld_chk_addr = 32'h300; ld_chk_size = SH; #1;
        check("ld_lh_after", 32'(ld_conflict), 32'd0);

        // Misaligned halfword is consumed and dropped
        enq(32'h401, 32'h0000_1234, SH);
        check("mis_pulse", 32'(misalign_err), 32'd1);
        check("mis_count", 32'(count), 32'd0);
        tick();
        check("mis_pulse_end", 32'(misalign_err), 32'd0);

        // Reset mid-drain abandons pending stores
        enq(32'h500, 32'h5555_5555, SW);
        enq(32'h504, 32'h6666_6666, SW);
        check("pre_rst_valid", 32'(mem_req_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(mem_req_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Post-commit store buffer directly downstream of the load-store queue.
- Accepts committed stores (address, data, mem_size_t size) from the LSQ commit port and holds them in an in-order FIFO.
- Drains the stores to data memory as word-aligned writes with byte enables, using a valid/ready handshake.
- Flags any in-flight load that overlaps a pending store, so the LSQ holds that load until the store reaches memory.

Parameters:
- SDB_DEPTH, 4, number of buffered stores (power of 2, >=2)
- DATA_WIDTH, 32, data/address width (matches lsq_package)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- enq_valid  input  1  LSQ presents a committed store
- enq_ready  output  1  buffer can accept the store this cycle
- enq_addr  input  32  byte address of the store
- enq_data  input  32  store data, LSB-justified
- enq_size  input  2  mem_size_t encoding (BYTE/HALF/WORD/RSVD)
- misalign_err  output  1  one-cycle pulse: a misaligned or RSVD store was dropped
- mem_req_valid  output  1  write request to data memory
- mem_req_ready  input  1  memory accepts the request
- mem_req_addr  output  32  word address, bits [1:0] always 0
- mem_req_wdata  output  32  byte-lane-positioned write data
- mem_req_be  output  4  byte enables
- ld_chk_addr  input  32  byte address of the load being checked
- ld_chk_size  input  2  mem_size_t encoding of that load
- ld_conflict  output  1  combinational: some pending store overlaps the load's bytes
- empty  output  1  no pending stores (used for fence/drain)
- count  output  $clog2(SDB_DEPTH)+1  number of occupied entries

Behaviour:
- Reset (synchronous, active-high):
  - Pointers and count go to 0; all entry valid bits are cleared.
  - Outputs after reset: enq_ready=1, empty=1, mem_req_valid=0, misalign_err=0, ld_conflict=0, count=0.
  - Reset asserted mid-drain abandons the outstanding request. mem_req_valid drops on the next edge and the memory side must tolerate this.
- Enqueue:
  - A store is accepted when enq_valid && enq_ready.
  - enq_ready = (count < SDB_DEPTH). There is no pass-through when full, even if a dequeue happens in the same cycle.
  - At accept, the entry stores:
    - word address = {enq_addr[31:2], 2'b00}
    - be = generate_byte_enable(enq_addr[1:0], size)
    - wdata = insert_bytes(enq_data, enq_addr[1:0], size)
- Alignment check:
  - HALF with enq_addr[0]=1, WORD with enq_addr[1:0]!=0, or size RSVD: the store is handshaked (consumed) but not written into the FIFO.
  - misalign_err pulses high for exactly the cycle after acceptance. count is unchanged.
- Drain:
  - mem_req_valid = !empty. The request fields come straight from the head entry registers.
  - Latency: a store accepted at edge N appears on the mem_req_* ports in the cycle after edge N.
  - The request is held stable until mem_req_ready. On valid&&ready the head pointer advances at that edge.
  - Stores leave strictly in enqueue order.
- Counters:
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Pointers wrap modulo SDB_DEPTH. count saturates logically at SDB_DEPTH; an overflow is impossible by construction of enq_ready.
- Load check:
  - Load mask = generate_byte_enable(ld_chk_addr[1:0], ld_chk_size).
  - ld_conflict = OR over valid entries of ((entry.addr[31:2] == ld_chk_addr[31:2]) && |(entry.be & load mask)).
  - The check covers stored entries only; a store being enqueued in the same cycle is not checked.
  - An entry in its dequeue handshake cycle still counts as a conflict.
- empty = (count == 0). count is registered.

Test Plan:
- Reset then idle:
  - Stimulus: reset held 2 cycles.
  - Required: enq_ready=1, empty=1, mem_req_valid=0, count=0.
- SB placement:
  - Stimulus: SB addr=0x1003, data=0x000000A5, then mem_req_ready=1.
  - Required: next cycle mem_req_addr=0x1000, be=4'b1000, wdata=0xA5000000. After the handshake, empty=1.
- Fill and backpressure:
  - Stimulus: 5 SW stores to 0x100,0x104,0x108,0x10C,0x110 with mem_req_ready=0.
  - Required: first 4 accepted, count=4, enq_ready=0, 5th stalls.
  - Then assert ready one cycle: 0x100 drains, enq_ready=1 the next cycle, 5th accepted.
  - Order on memory port: 0x100,0x104,0x108,0x10C,0x110.
- Simultaneous enqueue/dequeue:
  - Stimulus: count=2, mem_req_ready=1, enq of SH addr=0x202 data=0xBEEF in the same cycle.
  - Required: count stays 2. The later request shows be=4'b1100, wdata=0xBEEF0000.
- Load conflict:
  - Stimulus: pending SB 0x300 (be 0001). Check LB 0x301, then LH 0x300, then LW 0x304.
  - Required: ld_conflict = 0, 1, 0 respectively.
  - After the store drains, LH 0x300 gives 0.
- Misalign/reset:
  - Stimulus: SH addr=0x401.
  - Required: accepted, misalign_err=1 for one cycle, count=0.
  - Then enqueue 2 stores, assert reset while mem_req_valid=1: next cycle mem_req_valid=0, count=0, empty=1.
